// File: rtl/adder_ctrl_pkg.sv
// Shared types and helpers for the multi-word add/subtract controller.
package adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/full_adder.sv
// WIDTH-bit ripple adder with carry-in and carry-out; the only arithmetic in the controller.
module full_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/multiword_adder_ctrl.sv
// Sequences one WIDTH-bit full_adder over WORDS operand words (LS word first) to add or
// subtract WIDTH*WORDS-bit operands, with valid/ready handshakes on both sides.
module multiword_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   op_sub,
  input  logic                   c_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   c_out,
  output logic                   ovf
);

  localparam int N    = WIDTH * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e            state_q, state_d;
  logic [N-1:0]      a_q, a_d;
  logic [N-1:0]      b_q, b_d;
  logic [N-1:0]      sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              c_out_q, c_out_d;
  logic              ovf_q, ovf_d;
  logic [IDXW-1:0]   idx_q, idx_d;

  logic [31:0]       base_s;
  logic [WIDTH-1:0]  fa_sum_s;
  logic              fa_co_s;
  logic              last_s;

  assign base_s = 32'(idx_q) * 32'(WIDTH);
  assign last_s = (idx_q == IDXW'(WORDS - 1));

  full_adder #(.WIDTH(WIDTH)) u_fa (
    .a    (a_q[base_s +: WIDTH]),
    .b    (b_q[base_s +: WIDTH]),
    .cin  (carry_q),
    .s    (fa_sum_s),
    .cout (fa_co_s)
  );

  // Next-state and datapath updates; op_sub is folded into B and the initial carry,
  // so it needs no register of its own.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : c_in;
          idx_d   = {IDXW{1'b0}};
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[base_s +: WIDTH] = fa_sum_s;
        carry_d                = fa_co_s;
        if (last_s) begin
          idx_d   = {IDXW{1'b0}};
          c_out_d = fa_co_s;
          ovf_d   = ovf_calc(a_q[N-1], b_q[N-1], fa_sum_s[WIDTH-1]);
          state_d = DONE;
        end else begin
          idx_d   = idx_q + IDXW'(1);
          state_d = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= {N{1'b0}};
      b_q     <= {N{1'b0}};
      sum_q   <= {N{1'b0}};
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= {IDXW{1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_multiword_adder_ctrl.sv
// Scoreboard bench: the driver pushes hand-computed results, a negedge monitor checks them.
module tb_multiword_adder_ctrl;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         op_sub;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         c_out;
  logic         ovf;

  typedef struct {
    logic [N-1:0] sum;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic ov_prev = 1'b0;

  multiword_adder_ctrl #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, result on each handshake.
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      if (q.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
      else chk("latency", 64'(cyc - q[0].acc), 64'(WORDS));
    end
    if (out_valid && out_ready && q.size() > 0) begin
      chk("sum",   64'(sum),   64'(q[0].sum));
      chk("c_out", 64'(c_out), 64'(q[0].co));
      chk("ovf",   64'(ovf),   64'(q[0].ov));
      void'(q.pop_front());
    end
    ov_prev = out_valid;
  end

  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv, input logic sub,
                       input logic ci, input logic push,
                       input logic [N-1:0] es, input logic eco, input logic eov);
    exp_t e;
    int   n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
    a = av; b = bv; op_sub = sub; c_in = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.sum = es; e.co = eco; e.ov = eov; e.acc = cyc;
    if (push) q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() > 0) begin
      chk("drain_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op_sub = 1'b0; c_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum",       64'(sum),       64'd0);
    chk("rst_c_out",     64'(c_out),     64'd0);
    chk("rst_ovf",       64'(ovf),       64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    issue(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00000100, 1'b0, 1'b0); drain();
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0); drain();
    issue(32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0); drain();
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1); drain();
    issue(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0); drain();
    issue(32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1); drain();

    // Backpressure: DONE must hold while in_valid and operands wiggle.
    out_ready = 1'b0;
    issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, 1'b1, 32'h23456789, 1'b0, 1'b0);
    begin
      int n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (!out_valid) chk("bp_done_timeout", 64'd0, 64'd1);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 32'hDEAD0000 + 32'(i);
      b = 32'h0000BEEF ^ 32'(i);
      @(posedge clk); #1;
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready",  64'(in_ready),  64'd0);
      chk("bp_sum",       64'(sum),       64'h23456789);
      chk("bp_c_out",     64'(c_out),     64'd0);
      chk("bp_ovf",       64'(ovf),       64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready",  64'(in_ready),  64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    drain();
    issue(32'h00000010, 32'h00000010, 1'b1, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0); drain();

    // Reset two cycles into RUN aborts with no result.
    issue(32'hAAAAAAAA, 32'h11111111, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("run_in_ready", 64'(in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready",  64'(in_ready),  64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_sum",       64'(sum),       64'd0);
    chk("abort_c_out",     64'(c_out),     64'd0);
    chk("abort_ovf",       64'(ovf),       64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 64'(out_valid), 64'd0);
    end
    issue(32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h00000002, 1'b0, 1'b0); drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
